ncc_search_ctrl: RTL and testbench

Job sequencer for the ncc correlation engine. It accepts a search job and streams one 256-pixel descriptor into ncc as 64 beats of 36 bits. It then issues N candidate-window strobes, waiting for ncc to finish each window before the next, and returns ncc's best score and index as a held result. Window pixel data goes straight from the window buffer to ncc; this block owns only the handshakes, sequencing and result capture.

---
 rtl/ncc_pkg.sv | 20 ++
 rtl/ncc_search_ctrl.sv | 121 ++++++++++++
 tb/tb_ncc_search_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ncc_pkg.sv
// rtl/ncc_pkg.sv - shared widths and FSM state encoding for the ncc job sequencer
package ncc_pkg;
   localparam int DESC_BEATS = 64;
   localparam int PIX_W      = 9;
   localparam int DESC_W     = 4 * PIX_W;
   localparam int IDX_W      = 13;
   localparam int NCC_W      = 64;
   localparam int BEAT_W     = $clog2(DESC_BEATS);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      LOAD_DESC,
      WAIT_DESC,
      REQ_WIN,
      WAIT_WIN,
      CAPTURE,
      RESULT
   } state_t;
endpackage

// File: rtl/ncc_search_ctrl.sv
// rtl/ncc_search_ctrl.sv - sequences descriptor load, window strobes and result capture for ncc
module ncc_search_ctrl
   import ncc_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [IDX_W-1:0]  num_windows,
   output logic              busy,
   output logic              job_err,
   input  logic              desc_valid,
   input  logic [DESC_W-1:0] desc_word,
   output logic              desc_ready,
   input  logic              win_valid,
   output logic              win_ready,
   output logic              ncc_clear,
   output logic              ncc_desc_data_ready,
   output logic [DESC_W-1:0] ncc_desc_in,
   output logic              ncc_window_data_ready,
   input  logic              ncc_done_with_desc_data,
   input  logic              ncc_done_with_window_data,
   input  logic [NCC_W-1:0]  ncc_greatest_ncc,
   input  logic [IDX_W-1:0]  ncc_greatest_win_index,
   output logic [IDX_W-1:0]  win_count,
   output logic              result_valid,
   output logic [NCC_W-1:0]  result_ncc,
   output logic [IDX_W-1:0]  result_index,
   input  logic              result_ack
);

   state_t              state, state_nxt;
   logic [BEAT_W-1:0]   beat_cnt;
   logic [IDX_W-1:0]    num_lat;
   logic                abort_hit;
   logic                job_accept;

   // Abort is not honoured in IDLE (nothing to cancel) or RESULT (result already owed to consumer).
   assign abort_hit  = abort && (state != IDLE) && (state != RESULT);
   assign job_accept = (state == IDLE) && start && (num_windows != '0);

   always_comb begin
      state_nxt             = state;
      busy                  = (state != IDLE);
      job_err               = (state == IDLE) && start && (num_windows == '0);
      desc_ready            = 1'b0;
      win_ready             = 1'b0;
      ncc_clear             = 1'b0;
      case (state)
         IDLE:      if (job_accept) state_nxt = CLEAR;
         CLEAR: begin
            ncc_clear = 1'b1;
            state_nxt = LOAD_DESC;
         end
         LOAD_DESC: begin
            desc_ready = 1'b1;
            if (desc_valid && (beat_cnt == BEAT_W'(DESC_BEATS - 1))) state_nxt = WAIT_DESC;
         end
         WAIT_DESC: if (ncc_done_with_desc_data) state_nxt = REQ_WIN;
         REQ_WIN: begin
            win_ready = 1'b1;
            if (win_valid) state_nxt = WAIT_WIN;
         end
         WAIT_WIN: begin
            if (ncc_done_with_window_data)
               state_nxt = ((win_count + IDX_W'(1)) == num_lat) ? CAPTURE : REQ_WIN;
         end
         CAPTURE:   state_nxt = RESULT;
         RESULT:    if (result_ack) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
      if (abort_hit) begin
         state_nxt  = IDLE;
         desc_ready = 1'b0;
         win_ready  = 1'b0;
         ncc_clear  = 1'b0;
      end
   end

   assign ncc_desc_data_ready   = desc_valid & desc_ready;
   assign ncc_desc_in           = desc_word;
   assign ncc_window_data_ready = win_valid & win_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         beat_cnt     <= '0;
         num_lat      <= '0;
         win_count    <= '0;
         result_valid <= 1'b0;
         result_ncc   <= '0;
         result_index <= '0;
      end else begin
         state <= state_nxt;
         if (abort_hit) begin
            beat_cnt  <= '0;
            win_count <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (job_accept) begin
                     num_lat   <= num_windows;
                     win_count <= '0;
                  end
               end
               CLEAR:     beat_cnt <= '0;
               LOAD_DESC: if (desc_valid) beat_cnt <= beat_cnt + BEAT_W'(1);
               WAIT_WIN:  if (ncc_done_with_window_data) win_count <= win_count + IDX_W'(1);
               CAPTURE: begin
                  result_ncc   <= ncc_greatest_ncc;
                  result_index <= ncc_greatest_win_index;
                  result_valid <= 1'b1;
               end
               RESULT:    if (result_ack) result_valid <= 1'b0;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ncc_search_ctrl.sv
// tb/tb_ncc_search_ctrl.sv - scoreboard bench for the ncc job sequencer
module tb_ncc_search_ctrl;
   import ncc_pkg::*;

   typedef struct {
      logic [NCC_W-1:0] ncc;
      logic [IDX_W-1:0] idx;
      logic [IDX_W-1:0] cnt;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              start, abort;
   logic [IDX_W-1:0]  num_windows;
   logic              busy, job_err;
   logic              desc_valid;
   logic [DESC_W-1:0] desc_word;
   logic              desc_ready, win_valid, win_ready, ncc_clear;
   logic              ncc_desc_data_ready, ncc_window_data_ready;
   logic [DESC_W-1:0] ncc_desc_in;
   logic              done_desc, done_win;
   logic [NCC_W-1:0]  greatest_ncc;
   logic [IDX_W-1:0]  greatest_idx;
   logic [IDX_W-1:0]  win_count;
   logic              result_valid;
   logic [NCC_W-1:0]  result_ncc;
   logic [IDX_W-1:0]  result_index;
   logic              result_ack;

   int checks = 0;
   int errors = 0;
   int clear_cnt = 0;
   int win_strobe_cnt = 0;
   int results_seen = 0;
   logic rv_q = 1'b0;
   exp_t sb[$];

   localparam logic [DESC_W-1:0] DW = {9'h1FF, 9'h001, 9'h1FF, 9'h001};

   always #5 clk = ~clk;

   ncc_search_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .num_windows(num_windows),
      .busy(busy), .job_err(job_err), .desc_valid(desc_valid), .desc_word(desc_word),
      .desc_ready(desc_ready), .win_valid(win_valid), .win_ready(win_ready),
      .ncc_clear(ncc_clear), .ncc_desc_data_ready(ncc_desc_data_ready),
      .ncc_desc_in(ncc_desc_in), .ncc_window_data_ready(ncc_window_data_ready),
      .ncc_done_with_desc_data(done_desc), .ncc_done_with_window_data(done_win),
      .ncc_greatest_ncc(greatest_ncc), .ncc_greatest_win_index(greatest_idx),
      .win_count(win_count), .result_valid(result_valid), .result_ncc(result_ncc),
      .result_index(result_index), .result_ack(result_ack)
   );

   // Strobe counters and result scoreboard, sampled mid-cycle.
   always @(negedge clk) begin
      if (ncc_clear) clear_cnt++;
      if (ncc_window_data_ready) win_strobe_cnt++;
      if (result_valid && !rv_q) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_unexpected_result got ncc=%h idx=%0d expected none", result_ncc, result_index);
         end else begin
            exp_t e;
            e = sb.pop_front();
            results_seen++;
            if (result_ncc !== e.ncc || result_index !== e.idx || win_count !== e.cnt) begin
               errors++;
               $display("FAIL scoreboard_result got ncc=%h idx=%0d cnt=%0d expected ncc=%h idx=%0d cnt=%0d",
                        result_ncc, result_index, win_count, e.ncc, e.idx, e.cnt);
            end
         end
      end
      rv_q <= result_valid;
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Start pulse, then advance through CLEAR so the caller begins in LOAD_DESC.
   task automatic start_job(input int n);
      start = 1'b1; num_windows = IDX_W'(n);
      step();
      start = 1'b0;
      step();
   endtask

   task automatic load_desc(input bit gap, input int inject_at, output int ready_cycles, output int beats);
      bit phase = 1'b1;
      beats = 0; ready_cycles = 0;
      for (int c = 0; c < 400 && beats < DESC_BEATS; c++) begin
         desc_valid = gap ? phase : 1'b1;
         phase      = ~phase;
         desc_word  = DW;
         if (beats == inject_at) begin start = 1'b1; num_windows = 13'd5; end
         else start = 1'b0;
         @(negedge clk);
         if (desc_ready) ready_cycles++;
         if (ncc_desc_data_ready) beats++;
         step();
      end
      desc_valid = 1'b0; start = 1'b0; desc_word = '0;
   endtask

   task automatic finish_desc();
      step(); step();
      done_desc = 1'b1;
      step();
      done_desc = 1'b0;
   endtask

   task automatic run_window(input bit send_done);
      bit seen = 1'b0;
      win_valid = 1'b1;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (ncc_window_data_ready) seen = 1'b1;
         else step();
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL window_strobe_timeout got none expected strobe");
      end
      step();
      win_valid = 1'b0;
      if (send_done) begin
         step();
         done_win = 1'b1;
         step();
         done_win = 1'b0;
      end
   endtask

   task automatic wait_result();
      bit seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (result_valid) seen = 1'b1;
         else step();
      end
      step();
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL result_timeout got result_valid=0 expected 1");
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({busy, job_err, desc_ready, win_ready, ncc_clear, ncc_desc_data_ready,
           ncc_window_data_ready, result_valid} !== 8'h00 || win_count !== '0 ||
          result_ncc !== '0 || result_index !== '0) begin
         errors++;
         $display("FAIL reset_outputs got busy=%b rv=%b cnt=%0d ncc=%h expected all zero",
                  busy, result_valid, win_count, result_ncc);
      end
   endtask

   task automatic test_nominal();
      int rc, b, c0, w0;
      c0 = clear_cnt; w0 = win_strobe_cnt;
      greatest_ncc = 64'h0000_0001_0000_0000; greatest_idx = 13'd2;
      sb.push_back('{ncc: 64'h0000_0001_0000_0000, idx: 13'd2, cnt: 13'd3});
      start_job(3);
      checks++;
      if (clear_cnt - c0 !== 1) begin
         errors++; $display("FAIL nominal_clear got %0d expected 1", clear_cnt - c0);
      end
      desc_valid = 1'b1; desc_word = DW; #1;
      checks++;
      if (ncc_desc_in !== DW) begin
         errors++; $display("FAIL nominal_desc_passthrough got %h expected %h", ncc_desc_in, DW);
      end
      load_desc(1'b0, -1, rc, b);
      checks++;
      if (b !== 64 || rc !== 64) begin
         errors++; $display("FAIL nominal_desc_beats got beats=%0d ready=%0d expected 64/64", b, rc);
      end
      finish_desc();
      for (int w = 0; w < 3; w++) run_window(1'b1);
      checks++;
      if (win_strobe_cnt - w0 !== 3) begin
         errors++; $display("FAIL nominal_win_strobes got %0d expected 3", win_strobe_cnt - w0);
      end
      wait_result();
      result_ack = 1'b1; step(); result_ack = 1'b0;
      checks++;
      if (result_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL nominal_ack got rv=%b busy=%b expected 0/0", result_valid, busy);
      end
   endtask

   task automatic test_gapped();
      int rc, b;
      greatest_ncc = 64'hFFFF_FFFF_8000_0000; greatest_idx = 13'd0;
      sb.push_back('{ncc: 64'hFFFF_FFFF_8000_0000, idx: 13'd0, cnt: 13'd1});
      start_job(1);
      load_desc(1'b1, -1, rc, b);
      checks++;
      if (b !== 64 || rc !== 127) begin
         errors++; $display("FAIL gapped_load got beats=%0d ready=%0d expected 64/127", b, rc);
      end
      desc_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (desc_ready !== 1'b0 || ncc_desc_data_ready !== 1'b0) begin
         errors++; $display("FAIL gapped_extra_beat got ready=%b strobe=%b expected 0/0", desc_ready, ncc_desc_data_ready);
      end
      step(); desc_valid = 1'b0;
      done_desc = 1'b1; step(); done_desc = 1'b0;
      run_window(1'b1);
      wait_result();
      result_ack = 1'b1; step(); result_ack = 1'b0;
   endtask

   task automatic test_zero_busy_start();
      int rc, b, w0;
      start = 1'b1; num_windows = '0;
      @(negedge clk);
      checks++;
      if (job_err !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL zero_start got job_err=%b busy=%b expected 1/0", job_err, busy);
      end
      step(); start = 1'b0;
      @(negedge clk);
      checks++;
      if (job_err !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL zero_start_after got job_err=%b busy=%b expected 0/0", job_err, busy);
      end
      step();
      w0 = win_strobe_cnt;
      greatest_ncc = 64'h0000_0000_4000_0000; greatest_idx = 13'd1;
      sb.push_back('{ncc: 64'h0000_0000_4000_0000, idx: 13'd1, cnt: 13'd2});
      start_job(2);
      load_desc(1'b0, 10, rc, b);
      finish_desc();
      for (int w = 0; w < 2; w++) run_window(1'b1);
      wait_result();
      checks++;
      if (win_strobe_cnt - w0 !== 2) begin
         errors++; $display("FAIL busy_start_windows got %0d expected 2", win_strobe_cnt - w0);
      end
      result_ack = 1'b1; step(); result_ack = 1'b0;
   endtask

   task automatic test_abort();
      int rc, b, c0;
      start_job(4);
      load_desc(1'b0, -1, rc, b);
      finish_desc();
      run_window(1'b1);
      run_window(1'b0);
      abort = 1'b1; win_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (win_ready !== 1'b0 || ncc_window_data_ready !== 1'b0 || ncc_clear !== 1'b0) begin
         errors++; $display("FAIL abort_strobes got win_ready=%b strobe=%b expected 0/0", win_ready, ncc_window_data_ready);
      end
      step(); abort = 1'b0; win_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || result_valid !== 1'b0 || win_count !== '0) begin
         errors++; $display("FAIL abort_idle got busy=%b rv=%b cnt=%0d expected 0/0/0", busy, result_valid, win_count);
      end
      step();
      c0 = clear_cnt;
      greatest_ncc = 64'h0000_0002_0000_0000; greatest_idx = 13'd0;
      sb.push_back('{ncc: 64'h0000_0002_0000_0000, idx: 13'd0, cnt: 13'd1});
      start_job(1);
      load_desc(1'b0, -1, rc, b);
      checks++;
      if (clear_cnt - c0 !== 1 || rc !== 64 || b !== 64) begin
         errors++; $display("FAIL abort_restart got clears=%0d ready=%0d beats=%0d expected 1/64/64", clear_cnt - c0, rc, b);
      end
      finish_desc();
      run_window(1'b1);
      wait_result();
      result_ack = 1'b1; step(); result_ack = 1'b0;
   endtask

   task automatic test_backpressure();
      int rc, b;
      int bad = 0;
      greatest_ncc = 64'h0000_0000_0000_0005; greatest_idx = 13'd0;
      sb.push_back('{ncc: 64'h0000_0000_0000_0005, idx: 13'd0, cnt: 13'd1});
      start_job(1);
      load_desc(1'b0, -1, rc, b);
      finish_desc();
      run_window(1'b1);
      wait_result();
      for (int c = 0; c < 20; c++) begin
         greatest_ncc = 64'(c + 100); greatest_idx = IDX_W'(c + 7);
         @(negedge clk);
         if (result_valid !== 1'b1 || result_ncc !== 64'h5 || result_index !== '0) bad++;
         step();
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL backpressure_hold got %0d unstable cycles expected 0", bad);
      end
      result_ack = 1'b1; step(); result_ack = 1'b0;
      @(negedge clk);
      checks++;
      if (result_valid !== 1'b0) begin
         errors++; $display("FAIL backpressure_ack got rv=%b expected 0", result_valid);
      end
      step();
   endtask

   task automatic test_async_reset();
      int rc, b;
      start_job(2);
      load_desc(1'b0, -1, rc, b);
      finish_desc();
      #3 rst = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || win_ready !== 1'b0 || desc_ready !== 1'b0 || result_valid !== 1'b0 ||
          win_count !== '0 || result_ncc !== '0 || result_index !== '0 || ncc_clear !== 1'b0) begin
         errors++; $display("FAIL async_reset got busy=%b win_ready=%b ncc=%h expected all zero", busy, win_ready, result_ncc);
      end
      step(); step();
      rst = 1'b1;
      step();
      checks++;
      if (busy !== 1'b0 || win_ready !== 1'b0) begin
         errors++; $display("FAIL async_reset_release got busy=%b win_ready=%b expected 0/0", busy, win_ready);
      end
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; abort = 1'b0; num_windows = '0;
      desc_valid = 1'b0; desc_word = '0; win_valid = 1'b0;
      done_desc = 1'b0; done_win = 1'b0; greatest_ncc = '0; greatest_idx = '0;
      result_ack = 1'b0;
      test_reset();
      step(); step();
      rst = 1'b1;
      step();
      test_nominal();
      test_gapped();
      test_zero_busy_start();
      test_abort();
      test_backpressure();
      test_async_reset();
      checks++;
      if (sb.size() != 0 || results_seen != 5) begin
         errors++; $display("FAIL scoreboard_drain got pending=%0d seen=%0d expected 0/5", sb.size(), results_seen);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
